cpu_mem_responder: RTL
======================

// Module: cpu_mem_responder
// PURPOSE
// - Memory-side responder for the accumulator CPU's fetch/read/write accesses: 16 x 8-bit word store.
// - CPU core is the initiator (instruction fetch via AR, operand read M[AR], store AC / M[AR] updates).
// - Handshaked request/response channels; separate load port lets the bench preload programs.
// - Sits between CPU core and bench/top-level; single storage owner for the whole CPU.
// PARAMETERS
// - ADDR_W  4  address width; depth = 2**ADDR_W words
// - DATA_W  8  word width (I bit + 3-bit opcode + 4-bit address)
// - RD_LAT  1  wait cycles between acceptance and rsp_valid (legal 0..3)
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       asynchronous active-low reset
// - req_valid  in   1       CPU request present
// - req_ready  out  1       responder accepts request this cycle
// - req_we     in   1       1 = write, 0 = read/fetch
// - req_addr   in   ADDR_W  word address
// - req_wdata  in   DATA_W  write data
// - rsp_valid  out  1       response present
// - rsp_ready  in   1       CPU takes response
// - rsp_rdata  out  DATA_W  read data (write: echo of written data)
// - rsp_err    out  1       parity error on read (0 when MEM_PARITY_EN undefined)
// - ld_en      in   1       bench load strobe, priority over CPU
// - ld_addr    in   ADDR_W  load address
// - ld_data    in   DATA_W  load data
// - busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
// - Reset: state IDLE, req_ready 0 during reset, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, all words 0.
// - FSM: IDLE -> (accept, RD_LAT>0) WAIT -> RESP; IDLE -> (accept, RD_LAT=0) RESP; RESP -> (rsp_ready) IDLE.
// - req_ready = (state==IDLE) & ~ld_en; accept = req_valid & req_ready; one outstanding request max.
// - Read: M[req_addr] captured into rsp_rdata on the accept edge; later loads do not alter it.
// - Write: M[req_addr] <= req_wdata on the accept edge; rsp_rdata <= req_wdata.
// - Latency: rsp_valid rises exactly RD_LAT+1 edges after accept edge's cycle (RD_LAT=1 -> 2 cycles).
// - WAIT counter counts 0..RD_LAT-1, then RESP; counter cleared on entry.
// - RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_ready; drop to 0 the edge after handshake.
// - No back-to-back in RESP: new request accepted earliest the cycle after response handshake.
// - ld_en: M[ld_addr] <= ld_data every edge it is high, any state; blocks acceptance only.
// - Addresses wrap naturally (ADDR_W bits); no out-of-range case.
// - Reset mid-operation: pending response discarded, FSM to IDLE, memory cleared.
// CONFIGURATION
// - MEM_PARITY_EN defined: each word stores extra even-parity bit, computed on CPU write and load.
//   - Extra input par_inj (1 bit): when high on a write/load edge, stored parity is inverted.
//   - Read: rsp_err = stored parity != ^data; write responses rsp_err = 0; reset parity bits = 0 (valid for 0).
// - MEM_PARITY_EN undefined: no parity storage, no par_inj port, rsp_err tied 0.
// STRUCTURE
// - Package cpu_pkg: ADDR_W/DATA_W defaults, word_t/addr_t typedefs, state enum {IDLE, WAIT, RESP}.
// - Package also holds instruction field constants (I bit 7, opcode [6:4], address [3:0]) shared with core.
// - Sub-module cpu_mem_array: storage + two write ports (load > CPU on same address same edge) + parity.
// - Top holds FSM, latency counter, response registers.
// TESTING
// - Load 0x14 @3, read 3, RD_LAT=1 -> rsp_valid 2 cycles after accept, rsp_rdata 0x14, rsp_err 0.
// - Write 0xA5 @7 then read 7 -> write rsp echoes 0xA5; read returns 0xA5.
// - Hold rsp_ready 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0 throughout, busy 1.
// - ld_en high with req_valid high in IDLE -> no accept; ld_en low next cycle -> accept.
// - Read @2 accepted, load 0xFF @2 during WAIT -> response still old value; re-read returns 0xFF.
// - rst_n low during WAIT -> rsp_valid 0, busy 0, read of any address returns 0x00.
// - MEM_PARITY_EN: load 0x0F with par_inj=1 @4, read 4 -> rsp_err 1; reload with par_inj=0 -> rsp_err 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU: word/address widths,
// responder FSM states and instruction field positions used by the core.
package cpu_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   typedef logic [ADDR_W_DEF-1:0] addr_t;
   typedef logic [DATA_W_DEF-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Instruction word layout: I | opcode[2:0] | address[3:0]
   localparam int INS_I_BIT    = 7;
   localparam int INS_OP_MSB   = 6;
   localparam int INS_OP_LSB   = 4;
   localparam int INS_ADDR_MSB = 3;
   localparam int INS_ADDR_LSB = 0;

   function automatic logic ins_indirect(input word_t w);
      return w[INS_I_BIT];
   endfunction

   function automatic logic [2:0] ins_opcode(input word_t w);
      return w[INS_OP_MSB:INS_OP_LSB];
   endfunction

   function automatic addr_t ins_addr(input word_t w);
      return w[INS_ADDR_MSB:INS_ADDR_LSB];
   endfunction

   function automatic logic even_par(input word_t w);
      return ^w;
   endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Request/response bus between the CPU core (master) and the memory responder (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds valid and its payload stable until then, and ready may depend on valid.
interface cpu_mem_responder_if
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/cpu_mem_array.sv
// Word store with a load port and a CPU write port; load wins on a shared address.
// With MEM_PARITY_EN defined each word carries an even-parity bit that par_inj can corrupt.
module cpu_mem_array
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
`ifdef MEM_PARITY_EN
   input  logic              par_inj,
`endif
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_perr
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // The load write is issued last so it overrides a CPU write to the same word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) mem[wr_addr] <= wr_data;
         if (ld_en) mem[ld_addr] <= ld_data;
      end
   end

   assign rd_data = mem[rd_addr];

`ifdef MEM_PARITY_EN
   logic [DEPTH-1:0] par;

   // Cleared parity is consistent with cleared data, so reset leaves no errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par <= '0;
      end else begin
         if (wr_en) par[wr_addr] <= (^wr_data) ^ par_inj;
         if (ld_en) par[ld_addr] <= (^ld_data) ^ par_inj;
      end
   end

   assign rd_perr = par[rd_addr] != (^rd_data);
`else
   assign rd_perr = 1'b0;
`endif

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the accumulator CPU: one outstanding request, RD_LAT wait cycles.
// Optional word parity is enabled by defining MEM_PARITY_EN.
module cpu_mem_responder
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   cpu_mem_responder_if.slave bus,
   input  logic               ld_en,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [DATA_W-1:0]  ld_data,
`ifdef MEM_PARITY_EN
   input  logic               par_inj,
`endif
   output logic               busy,
   output state_t             dbg_state
);

   localparam logic [1:0] LAST_CNT  = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);
   localparam state_t     ACC_STATE = (RD_LAT > 0) ? WAIT : RESP;

   state_t            state, state_n;
   logic [1:0]        wait_cnt, wait_cnt_n;
   logic              ready_en;
   logic              accept;
   logic              rsp_fire;
   logic              wr_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_perr;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   // ready_en keeps req_ready low while reset is asserted and for the first edge after it.
   assign bus.req_ready = ready_en & (state == IDLE) & ~ld_en;
   assign accept        = bus.req_valid & bus.req_ready;
   assign rsp_fire      = (state == RESP) & bus.rsp_ready;
   assign wr_en         = accept & bus.req_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
         ready_en <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         ready_en <= 1'b1;
      end
   end

   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n    = ACC_STATE;
               wait_cnt_n = '0;
            end
         end
         WAIT: begin
            if (wait_cnt == LAST_CNT) state_n    = RESP;
            else                      wait_cnt_n = wait_cnt + 2'd1;
         end
         RESP: begin
            if (bus.rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Read data is captured at acceptance, so loads during WAIT/RESP cannot change it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         rdata_q <= bus.req_we ? bus.req_wdata : rd_data;
         err_q   <= ~bus.req_we & rd_perr;
      end else if (rsp_fire) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end
   end

   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign busy          = (state != IDLE);
   assign dbg_state     = state;

   cpu_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .wr_en   (wr_en),
      .wr_addr (bus.req_addr),
      .wr_data (bus.req_wdata),
`ifdef MEM_PARITY_EN
      .par_inj (par_inj),
`endif
      .rd_addr (bus.req_addr),
      .rd_data (rd_data),
      .rd_perr (rd_perr)
   );

endmodule
